// File: rtl/boot_copy.sv
// boot_copy: copies WORDS 32-bit words from ROM (SRC_BASE) to RAM (DST_BASE) over AXI-style channels.
// Define BOOT_COPY_CHECKSUM_EN to accumulate an additive checksum of successfully written words.
module boot_copy #(
    parameter logic [31:0] SRC_BASE = 32'h0000_0000,
    parameter logic [31:0] DST_BASE = 32'h8000_0000,
    parameter int unsigned WORDS    = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] checksum_o,
    output logic        rom_arvalid_o,
    input  logic        rom_arready_i,
    output logic [31:0] rom_araddr_o,
    input  logic        rom_rvalid_i,
    output logic        rom_rready_o,
    input  logic [31:0] rom_rdata_i,
    input  logic [1:0]  rom_rresp_i,
    output logic        ram_awvalid_o,
    input  logic        ram_awready_i,
    output logic [31:0] ram_awaddr_o,
    output logic        ram_wvalid_o,
    input  logic        ram_wready_i,
    output logic [31:0] ram_wdata_o,
    output logic [3:0]  ram_wstrb_o,
    input  logic        ram_bvalid_i,
    output logic        ram_bready_o,
    input  logic [1:0]  ram_bresp_i
);
    typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_idx;
    logic [31:0] r_data;
    logic        r_err, r_done, r_aw_ok, r_w_ok;
    logic        w_start, w_r_hs, w_b_hs, w_last, w_w_fin;

    assign w_start = (r_state == IDLE) && start_i;
    assign w_r_hs  = rom_rready_o && rom_rvalid_i;
    assign w_b_hs  = ram_bready_o && ram_bvalid_i;
    assign w_last  = {16'd0, r_idx} == WORDS - 1;
    // Each write channel may finish in an earlier cycle; the r_*_ok flags remember it.
    assign w_w_fin = (r_state == W) && (r_aw_ok || ram_awready_i) && (r_w_ok || ram_wready_i);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i && WORDS != 0) w_next = AR;
            AR:      if (rom_arready_i) w_next = R;
            R:       if (rom_rvalid_i) w_next = (rom_rresp_i != 2'b00) ? IDLE : W;
            W:       if (w_w_fin) w_next = B;
            B:       if (ram_bvalid_i) w_next = (ram_bresp_i != 2'b00 || w_last) ? IDLE : AR;
            default: w_next = IDLE;
        endcase
    end

    assign busy_o        = r_state != IDLE;
    assign done_o        = r_done;
    assign error_o       = r_err;
    assign rom_arvalid_o = r_state == AR;
    assign rom_araddr_o  = SRC_BASE + {14'd0, r_idx, 2'b00};
    assign rom_rready_o  = r_state == R;
    assign ram_awvalid_o = (r_state == W) && !r_aw_ok;
    assign ram_awaddr_o  = DST_BASE + {14'd0, r_idx, 2'b00};
    assign ram_wvalid_o  = (r_state == W) && !r_w_ok;
    assign ram_wdata_o   = r_data;
    assign ram_wstrb_o   = 4'hF;
    assign ram_bready_o  = r_state == B;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_aw_ok <= 1'b0;
            r_w_ok  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            r_aw_ok <= (r_state == W) && !w_w_fin && (r_aw_ok || ram_awready_i);
            r_w_ok  <= (r_state == W) && !w_w_fin && (r_w_ok || ram_wready_i);
            if (w_start) begin
                r_idx  <= '0;
                r_err  <= 1'b0;
                r_done <= WORDS == 0;
            end
            if (w_r_hs) begin
                r_data <= rom_rdata_i;
                if (rom_rresp_i != 2'b00) begin
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                end
            end
            if (w_b_hs) begin
                if (ram_bresp_i != 2'b00) begin
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                end else if (w_last) r_done <= 1'b1;
                else r_idx <= r_idx + 16'd1;
            end
        end
    end

`ifdef BOOT_COPY_CHECKSUM_EN
    logic [31:0] r_sum;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_sum <= '0;
        else if (w_start) r_sum <= '0;
        else if (w_b_hs && ram_bresp_i == 2'b00) r_sum <= r_sum + r_data;
    end
    assign checksum_o = r_sum;
`else
    assign checksum_o = 32'd0;
`endif
endmodule

// File: tb/tb_boot_copy.sv
// tb_boot_copy: randomized scoreboard bench for boot_copy with ROM/RAM slave models.
module tb_boot_copy;
    localparam int NW = 4;
    localparam logic [31:0] SRC = 32'h0000_1000;
    localparam logic [31:0] DST = 32'h8000_0040;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic busy, done, err;
    logic [31:0] csum, araddr, awaddr, wdata;
    logic arvalid, rready, awvalid, wvalid, bready;
    logic [3:0] wstrb;
    logic arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0] rresp = '0, bresp = '0;

    logic z_start = 1'b0, z_busy, z_done, z_err, z_arvalid, z_rready, z_awvalid, z_wvalid, z_bready;
    logic [31:0] z_csum, z_araddr, z_awaddr, z_wdata;
    logic [3:0] z_wstrb;
    logic z_bus = 1'b0;

    int checks = 0, fails = 0, n_done = 0, done_cyc = 0, n_aw = 0, n_w = 0, n_b = 0, cyc = 0;
    logic [63:0] exp_wr[$];
    logic [32:0] exp_done[$];
    bit zw = 1'b1, sk = 1'b0;
    int err_rd = -1, err_wr = -1;
    logic [31:0] rom[NW];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) z_bus <= z_bus | z_arvalid | z_awvalid | z_wvalid | z_rready | z_bready;

    boot_copy #(.SRC_BASE(SRC), .DST_BASE(DST), .WORDS(NW)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .error_o(err),
        .checksum_o(csum), .rom_arvalid_o(arvalid), .rom_arready_i(arready), .rom_araddr_o(araddr),
        .rom_rvalid_i(rvalid), .rom_rready_o(rready), .rom_rdata_i(rdata), .rom_rresp_i(rresp),
        .ram_awvalid_o(awvalid), .ram_awready_i(awready), .ram_awaddr_o(awaddr),
        .ram_wvalid_o(wvalid), .ram_wready_i(wready), .ram_wdata_o(wdata), .ram_wstrb_o(wstrb),
        .ram_bvalid_i(bvalid), .ram_bready_o(bready), .ram_bresp_i(bresp));

    boot_copy #(.WORDS(0)) u_zero (
        .clk_i(clk), .rst_i(rst_n), .start_i(z_start), .busy_o(z_busy), .done_o(z_done), .error_o(z_err),
        .checksum_o(z_csum), .rom_arvalid_o(z_arvalid), .rom_arready_i(1'b1), .rom_araddr_o(z_araddr),
        .rom_rvalid_i(1'b0), .rom_rready_o(z_rready), .rom_rdata_i(32'd0), .rom_rresp_i(2'b00),
        .ram_awvalid_o(z_awvalid), .ram_awready_i(1'b1), .ram_awaddr_o(z_awaddr),
        .ram_wvalid_o(z_wvalid), .ram_wready_i(1'b1), .ram_wdata_o(z_wdata), .ram_wstrb_o(z_wstrb),
        .ram_bvalid_i(1'b0), .ram_bready_o(z_bready), .ram_bresp_i(2'b00));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pairs AW/W beats into writes and checks them and every done_o against the scoreboard.
    initial begin : monitor
        logic [31:0] ma, md;
        logic [63:0] ew;
        logic [32:0] ed;
        bit ha, hd;
        ha = 0; hd = 0; ma = '0; md = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ha = 0; hd = 0;
            end else begin
                n_aw += int'(awvalid); n_w += int'(wvalid); n_b += int'(bready);
                if (awvalid && awready) begin ma = awaddr; ha = 1; end
                if (wvalid && wready) begin md = wdata; hd = 1; chk("wstrb", 32'(wstrb), 32'hF); end
                if (ha && hd) begin
                    ha = 0; hd = 0;
                    if (exp_wr.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_write: got addr %h data %h expected none", ma, md);
                    end else begin
                        ew = exp_wr.pop_front();
                        chk("wr_addr", ma, ew[63:32]);
                        chk("wr_data", md, ew[31:0]);
                    end
                end
                if (done) begin
                    n_done++; done_cyc = cyc;
                    if (exp_done.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        ed = exp_done.pop_front();
                        chk("done_error", 32'(err), 32'(ed[32]));
                        chk("done_checksum", csum, ed[31:0]);
                        chk("done_busy", 32'(busy), 32'd0);
                    end
                end
            end
        end
    end

    // ROM/RAM slaves: sample handshakes mid-cycle, drive just after the rising edge.
    initial begin : slaves
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rp, ga, gw;
        int ai, wi, wc;
        rp = 0; ga = 0; gw = 0; ai = 0; wi = 0; wc = 0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready; r_hs = rvalid && rready;
            aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
            if (ar_hs) ai = int'((araddr - SRC) >> 2);
            if (aw_hs) wi = int'((awaddr - DST) >> 2);
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rp = 0; ga = 0; gw = 0; wc = 0;
                rvalid = 0; bvalid = 0; arready = 0; awready = 0; wready = 0;
            end else begin
                if (r_hs) begin rvalid = 0; rp = 0; end
                if (ar_hs) begin
                    rp = 1;
                    rdata = (ai < NW) ? rom[ai] : 32'hDEAD_BEEF;
                    rresp = (ai == err_rd) ? 2'b10 : 2'b00;
                end
                if (rp && !rvalid && (zw || $urandom_range(1, 0) == 1)) rvalid = 1;
                arready = zw || $urandom_range(1, 0) == 1;
                if (b_hs) begin bvalid = 0; ga = 0; gw = 0; end
                if (aw_hs) ga = 1;
                if (w_hs) gw = 1;
                if (ga && gw && !bvalid && (zw || $urandom_range(1, 0) == 1)) begin
                    bvalid = 1;
                    bresp = (wi == err_wr) ? 2'b10 : 2'b00;
                end
                wc = wvalid ? wc + 1 : 0;
                awready = sk ? awvalid : (zw || $urandom_range(1, 0) == 1);
                wready = sk ? (wvalid && wc >= 4) : (zw || $urandom_range(1, 0) == 1);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({busy, done, err, arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk({tag, "_checksum"}, csum, 32'd0);
    endtask

    task automatic run(input bit zw_i, input bit sk_i, input bit seq, input int erd, input int ewr, input bit bs);
        logic [31:0] sum;
        bit e;
        int s, n0, a0, w0, b0, t;
        sum = '0; e = 0;
        zw = zw_i; sk = sk_i; err_rd = erd; err_wr = ewr;
        for (int i = 0; i < NW; i++) rom[i] = seq ? 32'(i + 1) : $urandom;
        for (int i = 0; i < NW && !e; i++) begin
            if (i == erd) e = 1;
            else begin
                exp_wr.push_back({DST + 32'(4 * i), rom[i]});
                if (i == ewr) e = 1;
                else sum += rom[i];
            end
        end
`ifdef BOOT_COPY_CHECKSUM_EN
        exp_done.push_back({e, sum});
`else
        exp_done.push_back({e, 32'd0});
`endif
        n0 = n_done; a0 = n_aw; w0 = n_w; b0 = n_b;
        @(posedge clk); #2;
        start = 1; s = cyc;
        @(posedge clk); #2;
        start = 0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (bs) begin
            @(posedge clk); #2 start = 1;
            @(posedge clk); #2 start = 0;
        end
        t = 0;
        while (n_done == n0 && t < 1000) begin @(posedge clk); t++; end
        if (n_done == n0) begin
            checks++; fails++;
            $display("FAIL done_timeout: got no done in %0d cycles expected one", t);
        end else if (zw && !sk && !e) chk("latency", 32'(done_cyc - s), 32'(4 * NW + 1));
        if (sk) begin
            chk("skew_aw_cycles", 32'(n_aw - a0), 32'(NW));
            chk("skew_w_cycles", 32'(n_w - w0), 32'(4 * NW));
            chk("skew_b_cycles", 32'(n_b - b0), 32'(NW));
        end
        repeat (3) @(posedge clk);
        chk("pending_writes", 32'(exp_wr.size()), 32'd0);
        chk("error_sticky", 32'(err), 32'(e));
    endtask

    initial begin
        int t, n0;
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #3;
        chk_zero("reset");
        rst_n = 1;
        run(1, 0, 1, -1, -1, 0);
        run(1, 0, 0, 1, -1, 0);
        run(1, 0, 0, -1, -1, 0);
        run(1, 1, 0, -1, -1, 0);
        run(1, 0, 0, -1, 2, 0);
        run(1, 0, 0, -1, -1, 1);
        for (int k = 0; k < 12; k++)
            run(0, 0, 0, ($urandom_range(3, 0) == 0) ? int'($urandom_range(NW - 1, 0)) : -1,
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(NW - 1, 0)) : -1, k % 4 == 3);
        zw = 1; sk = 0; err_rd = -1; err_wr = -1;
        for (int i = 0; i < NW; i++) rom[i] = $urandom;
        exp_wr.push_back({DST, rom[0]});
        exp_wr.push_back({DST + 32'd4, rom[1]});
        n0 = n_done;
        @(posedge clk); #2 start = 1;
        @(posedge clk); #2 start = 0;
        t = 0;
        while (!(awvalid && awaddr == DST + 32'd8) && t < 200) begin @(posedge clk); #3; t++; end
        chk("reach_word2_w", 32'(awvalid && awaddr == DST + 32'd8), 32'd1);
        rst_n = 0;
        #1;
        chk_zero("midreset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        repeat (6) @(posedge clk);
        chk("midreset_writes", 32'(exp_wr.size()), 32'd0);
        chk("midreset_no_done", 32'(n_done - n0), 32'd0);
        run(1, 0, 0, -1, -1, 0);
        @(posedge clk); #2 z_start = 1;
        @(posedge clk); #2 z_start = 0;
        chk("zero_done", 32'(z_done), 32'd1);
        chk("zero_busy", 32'(z_busy), 32'd0);
        @(posedge clk); #2;
        chk("zero_done_once", 32'(z_done), 32'd0);
        repeat (3) @(posedge clk);
        chk("zero_no_bus", 32'(z_bus), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
